// File: rtl/game_pkg.sv
// Shared types for the game-over controller: winner encoding and FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_GRACE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

endpackage

// File: rtl/winner_latch_ctrl_rise_edge.sv
// Rising-edge detector for a level input; the first cycle after reset never
// reports an edge, so a button held through reset stays silent.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & sig_i & ~prev_q;

endmodule

// File: rtl/winner_latch_ctrl.sv
// Game-flow FSM: decides the winner (with a draw window after the first hit),
// holds the game-over screen and accepts a restart once the hold has elapsed.
module winner_latch_ctrl
  import game_pkg::*;
#(
  parameter int DRAW_WINDOW = 8,
  parameter int OVER_HOLD   = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [1:0] winner_latched,
  output logic       game_over,
  output logic       play_en,
  output logic       restart
);

  localparam int CW = ($clog2(DRAW_WINDOW + 1) > 0) ? $clog2(DRAW_WINDOW + 1) : 1;
  localparam int HW = ($clog2(OVER_HOLD + 1) > 0) ? $clog2(OVER_HOLD + 1) : 1;
  localparam logic [CW-1:0] DW_C   = CW'(DRAW_WINDOW);
  localparam logic [HW-1:0] HOLD_C = HW'(OVER_HOLD);

  state_t        state_q;
  winner_t       winner_q;
  winner_t       pending_q;
  logic          game_over_q;
  logic          play_en_q;
  logic          restart_q;
  logic [CW-1:0] win_cnt_q;
  logic [CW-1:0] win_cnt_d;
  logic [HW-1:0] hold_q;
  logic          start_evt;
  logic          window_done;
  logic          survivor_hit;
  logic          hold_sat;

  rise_edge u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (start_btn),
    .rise_o (start_evt)
  );

  // The window counter saturates at DRAW_WINDOW; reaching it on this cycle's
  // tick counts as done, and a survivor hit on that same cycle still draws.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (frame_tick && (win_cnt_q < DW_C)) begin
      win_cnt_d = win_cnt_q + 1'b1;
    end
    window_done  = (win_cnt_d >= DW_C);
    survivor_hit = (pending_q == W_P2) ? p2_hit : p1_hit;
    hold_sat     = (hold_q >= HOLD_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      winner_q    <= W_NONE;
      pending_q   <= W_NONE;
      game_over_q <= 1'b0;
      play_en_q   <= 1'b0;
      restart_q   <= 1'b0;
      win_cnt_q   <= '0;
      hold_q      <= '0;
    end else begin
      restart_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_evt) begin
            state_q   <= S_PLAY;
            restart_q <= 1'b1;
            play_en_q <= 1'b1;
          end
        end
        S_PLAY: begin
          if (p1_hit && p2_hit) begin
            state_q     <= S_OVER;
            winner_q    <= W_DRAW;
            game_over_q <= 1'b1;
            play_en_q   <= 1'b0;
            hold_q      <= '0;
          end else if (p1_hit || p2_hit) begin
            state_q   <= S_GRACE;
            pending_q <= p1_hit ? W_P2 : W_P1;
            win_cnt_q <= '0;
          end
        end
        S_GRACE: begin
          if (survivor_hit || window_done) begin
            state_q     <= S_OVER;
            winner_q    <= survivor_hit ? W_DRAW : pending_q;
            game_over_q <= 1'b1;
            play_en_q   <= 1'b0;
            hold_q      <= '0;
          end else begin
            win_cnt_q <= win_cnt_d;
          end
        end
        S_OVER: begin
          if (hold_sat && start_evt) begin
            state_q     <= S_PLAY;
            restart_q   <= 1'b1;
            winner_q    <= W_NONE;
            pending_q   <= W_NONE;
            game_over_q <= 1'b0;
            play_en_q   <= 1'b1;
          end else if (frame_tick && !hold_sat) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign winner_latched = winner_q;
  assign game_over      = game_over_q;
  assign play_en        = play_en_q;
  assign restart        = restart_q;

endmodule
